// File: rtl/iob_regfile_wr_arbiter.sv
// ---------------------------------------------------------------------------
// iob_regfile_wr_arbiter
//
// Shares the single write port of a register file among N_REQ requesters
// using round-robin arbitration over valid/ready handshakes. After reset, or
// when clr_i is seen while arbitrating, every regfile address is first swept
// with INIT_VAL (addresses 0..2**ADDR_W-1, one per cycle). No requester is
// granted during the sweep.
//
// Ports
//   clk_i        clock, all state on rising edge
//   arst_n_i     asynchronous reset, active-low
//   clr_i        request a new init sweep (only honoured while arbitrating)
//   req_valid_i  per-requester write request
//   req_addr_i   packed addresses, requester k at [k*ADDR_W +: ADDR_W]
//   req_data_i   packed data, requester k at [k*DATA_W +: DATA_W]
//   req_ready_o  one-hot (or zero) combinational grant
//   busy_o       high while the init sweep is running
//   w_en_o       regfile write enable (registered)
//   w_addr_o     regfile write address (registered)
//   w_data_o     regfile write data (registered)
//   w_src_o      one-hot source of the current write, 0 for sweep writes
// ---------------------------------------------------------------------------
module iob_regfile_wr_arbiter #(
    parameter int                N_REQ    = 4,
    parameter int                ADDR_W   = 4,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic                      clk_i,
    input  logic                      arst_n_i,
    input  logic                      clr_i,
    input  logic [N_REQ-1:0]          req_valid_i,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
    input  logic [N_REQ*DATA_W-1:0]   req_data_i,
    output logic [N_REQ-1:0]          req_ready_o,
    output logic                      busy_o,
    output logic                      w_en_o,
    output logic [ADDR_W-1:0]         w_addr_o,
    output logic [DATA_W-1:0]         w_data_o,
    output logic [N_REQ-1:0]          w_src_o
);

    localparam int                PTR_W    = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [ADDR_W-1:0] CNT_LAST = '1;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_ARB  = 1'b1
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_cnt;
    logic [PTR_W-1:0]    r_ptr;

    logic                w_gnt_vld;
    logic [PTR_W-1:0]    w_gnt_idx;
    logic [N_REQ-1:0]    w_gnt_oh;
    logic [ADDR_W-1:0]   w_gnt_addr;
    logic [DATA_W-1:0]   w_gnt_data;
    logic                w_xfer;
    logic [PTR_W-1:0]    w_ptr_nxt;

    // Round-robin pick: first valid requester scanning upward from r_ptr,
    // wrapping modulo N_REQ. The winner's fields are muxed out here too.
    always_comb begin : grant_scan
        int k;
        k          = 0;
        w_gnt_vld  = 1'b0;
        w_gnt_idx  = '0;
        w_gnt_oh   = '0;
        w_gnt_addr = '0;
        w_gnt_data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = (int'(r_ptr) + i) % N_REQ;
            if (!w_gnt_vld && req_valid_i[k]) begin
                w_gnt_vld   = 1'b1;
                w_gnt_idx   = PTR_W'(k);
                w_gnt_oh[k] = 1'b1;
                w_gnt_addr  = req_addr_i[k*ADDR_W +: ADDR_W];
                w_gnt_data  = req_data_i[k*DATA_W +: DATA_W];
            end
        end
    end

    // clr_i suppresses the grant so no handshake completes on the cycle
    // that schedules a new sweep.
    assign w_xfer      = (r_state == ST_ARB) && !clr_i && w_gnt_vld;
    assign req_ready_o = w_xfer ? w_gnt_oh : '0;
    assign busy_o      = (r_state == ST_INIT);
    assign w_ptr_nxt   = PTR_W'((int'(w_gnt_idx) + 1) % N_REQ);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            r_state  <= ST_INIT;
            r_cnt    <= '0;
            r_ptr    <= '0;
            w_en_o   <= 1'b0;
            w_addr_o <= '0;
            w_data_o <= '0;
            w_src_o  <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    w_en_o   <= 1'b1;
                    w_addr_o <= r_cnt;
                    w_data_o <= INIT_VAL;
                    w_src_o  <= '0;
                    // Counter wraps to 0 naturally on the last address.
                    r_cnt    <= r_cnt + 1'b1;
                    if (r_cnt == CNT_LAST) begin
                        r_state <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    if (clr_i) begin
                        r_state <= ST_INIT;
                        r_cnt   <= '0;
                        w_en_o  <= 1'b0;
                        w_src_o <= '0;
                    end else if (w_xfer) begin
                        w_en_o   <= 1'b1;
                        w_addr_o <= w_gnt_addr;
                        w_data_o <= w_gnt_data;
                        w_src_o  <= w_gnt_oh;
                        // Winner drops to lowest priority for the next pick.
                        r_ptr    <= w_ptr_nxt;
                    end else begin
                        // Address/data hold their last value when idle.
                        w_en_o  <= 1'b0;
                        w_src_o <= '0;
                    end
                end
                default: begin
                    r_state <= ST_INIT;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
